game_state_controller: RTL and testbench

Match-level sequencer for the pong game, sitting directly downstream of the score counter. It watches `player1_score`/`player2_score` for increments, runs the IDLE → SERVE → PLAY → POINT → … → GAME_OVER flow, and drives `still_graphic` back to the score counter and the ball logic. It also issues a one-cycle serve strobe with direction, and a one-cycle `game_rst` pulse that clears scores when a new match starts.

---
 rtl/game_state_controller.sv | 155 +++++++++++++++
 tb/tb_game_state_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_controller.sv
// Match-level sequencer for pong: IDLE -> SERVE -> PLAY -> POINT -> ... -> GAME_OVER.
// Watches registered scores for increments and drives freeze, serve and match-reset controls.
module game_state_controller #(
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned SERVE_TICKS = 60,
  parameter int unsigned POINT_TICKS = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timing_tick,
  input  logic       start_btn,
  input  logic [3:0] player1_score,
  input  logic [3:0] player2_score,
  output logic       still_graphic,
  output logic       serve,
  output logic       serve_dir,
  output logic       game_rst,
  output logic [2:0] state,
  output logic [1:0] winner
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SCORE_W = 4;
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_TICKS - 1);
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_PLAY      = 3'd2,
    S_POINT     = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SCORE_W-1:0]   p1_q, p2_q;
  logic                 start_q;
  logic                 armed_q;
  logic                 still_q, serve_q, dir_q, grst_q;
  logic                 still_d, serve_d, dir_d, grst_d;
  logic [1:0]           winner_q, winner_d;

  logic start_rise, p1_inc, p2_inc;

  // armed_q masks the first cycle after reset so a button held through reset is not an edge
  assign start_rise = armed_q & start_btn & ~start_q;
  assign p1_inc     = player1_score > p1_q;
  assign p2_inc     = player2_score > p2_q;

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      start_q  <= 1'b0;
      armed_q  <= 1'b0;
      still_q  <= 1'b1;
      serve_q  <= 1'b0;
      dir_q    <= 1'b0;
      grst_q   <= 1'b0;
      winner_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p1_q     <= player1_score;
      p2_q     <= player2_score;
      start_q  <= start_btn;
      armed_q  <= 1'b1;
      still_q  <= still_d;
      serve_q  <= serve_d;
      dir_q    <= dir_d;
      grst_q   <= grst_d;
      winner_q <= winner_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    winner_d = winner_q;
    serve_d  = 1'b0;
    grst_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        winner_d = 2'b00;
        if (start_rise) begin
          grst_d  = 1'b1;
          dir_d   = 1'b0;
          state_d = S_SERVE;
        end
      end
      S_SERVE: begin
        if (timing_tick) begin
          if (cnt_q == SERVE_LAST) begin
            serve_d = 1'b1;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_PLAY: begin
        if (p1_inc) begin
          dir_d   = 1'b1;
          state_d = S_POINT;
        end else if (p2_inc) begin
          dir_d   = 1'b0;
          state_d = S_POINT;
        end
      end
      S_POINT: begin
        if (timing_tick) begin
          if (cnt_q == POINT_LAST) begin
            if (player1_score >= WIN) begin
              winner_d = 2'b01;
              state_d  = S_GAME_OVER;
            end else if (player2_score >= WIN) begin
              winner_d = 2'b10;
              state_d  = S_GAME_OVER;
            end else begin
              state_d = S_SERVE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_GAME_OVER: begin
        if (start_rise) begin
          winner_d = 2'b00;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
    still_d = (state_d != S_PLAY);
  end

  assign state         = state_q;
  assign still_graphic = still_q;
  assign serve         = serve_q;
  assign serve_dir     = dir_q;
  assign game_rst      = grst_q;
  assign winner        = winner_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Scoreboard bench for game_state_controller: expected output snapshots are queued as
// stimulus is driven and compared once the DUT has clocked the stimulus in.
module tb_game_state_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       timing_tick;
  logic       start_btn;
  logic [3:0] player1_score;
  logic [3:0] player2_score;
  logic       still_graphic;
  logic       serve;
  logic       serve_dir;
  logic       game_rst;
  logic [2:0] state;
  logic [1:0] winner;

  int n_checks = 0;
  int n_fail   = 0;
  int serve_cnt = 0;
  int grst_cnt  = 0;

  typedef struct {
    string      tag;
    logic [8:0] vec;
  } sb_entry_t;

  sb_entry_t sb[$];

  game_state_controller #(
    .WIN_SCORE  (9),
    .SERVE_TICKS(60),
    .POINT_TICKS(90)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .timing_tick  (timing_tick),
    .start_btn    (start_btn),
    .player1_score(player1_score),
    .player2_score(player2_score),
    .still_graphic(still_graphic),
    .serve        (serve),
    .serve_dir    (serve_dir),
    .game_rst     (game_rst),
    .state        (state),
    .winner       (winner)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (serve) serve_cnt++;
    if (game_rst) grst_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // {state, still_graphic, serve, serve_dir, game_rst, winner}
  function automatic logic [8:0] ev(input int st, input bit sg, input bit sv,
                                    input bit dir, input bit gr, input int w);
    return {3'(st), sg, sv, dir, gr, 2'(w)};
  endfunction

  function automatic logic [8:0] observed();
    return {state, still_graphic, serve, serve_dir, game_rst, winner};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_out();
    sb_entry_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 16'(1), 16'(0));
    end else begin
      e = sb.pop_front();
      check(e.tag, 16'(observed()), 16'(e.vec));
    end
  endtask

  task automatic exp_now(input string tag, input logic [8:0] vec);
    sb.push_back('{tag, vec});
    compare_out();
  endtask

  task automatic exp_step(input string tag, input logic [8:0] vec);
    sb.push_back('{tag, vec});
    step();
    compare_out();
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      timing_tick = 1'b1;
      step();
      timing_tick = 1'b0;
      step();
    end
  endtask

  task automatic tick_expect(input string tag, input logic [8:0] vec);
    timing_tick = 1'b1;
    sb.push_back('{tag, vec});
    step();
    timing_tick = 1'b0;
    compare_out();
  endtask

  int serve_base, grst_base;

  initial begin
    rst = 1'b1;
    timing_tick = 1'b0;
    start_btn = 1'b0;
    player1_score = 4'd0;
    player2_score = 4'd0;
    repeat (3) step();
    exp_now("reset", ev(0, 1, 0, 0, 0, 0));

    // Reset and start
    rst = 1'b0;
    repeat (2) step();
    exp_now("idle_wait", ev(0, 1, 0, 0, 0, 0));
    start_btn = 1'b1;
    exp_step("start_grst", ev(1, 1, 0, 0, 1, 0));
    start_btn = 1'b0;
    exp_step("grst_once", ev(1, 1, 0, 0, 0, 0));
    run_ticks(59);
    exp_now("serve_hold", ev(1, 1, 0, 0, 0, 0));
    tick_expect("serve_exit", ev(2, 0, 1, 0, 0, 0));
    exp_step("serve_once", ev(2, 0, 0, 0, 0, 0));

    // P1 point, scores moved during POINT are absorbed
    player1_score = 4'd1;
    exp_step("p1_point", ev(3, 1, 0, 1, 0, 0));
    player1_score = 4'd3;
    player2_score = 4'd3;
    exp_step("point_absorb", ev(3, 1, 0, 1, 0, 0));
    run_ticks(89);
    exp_now("point_hold", ev(3, 1, 0, 1, 0, 0));
    tick_expect("point_exit", ev(1, 1, 0, 1, 0, 0));
    run_ticks(59);
    tick_expect("serve_right", ev(2, 0, 1, 1, 0, 0));
    exp_step("serve_right_once", ev(2, 0, 0, 1, 0, 0));

    // Simultaneous increments: player 1 priority
    player1_score = 4'd4;
    player2_score = 4'd4;
    exp_step("both_inc", ev(3, 1, 0, 1, 0, 0));
    player1_score = 4'd5;
    player2_score = 4'd8;
    exp_step("single_point", ev(3, 1, 0, 1, 0, 0));
    run_ticks(89);
    tick_expect("both_exit", ev(1, 1, 0, 1, 0, 0));
    run_ticks(59);
    tick_expect("serve_again", ev(2, 0, 1, 1, 0, 0));
    step();

    // Non-increments in PLAY
    serve_base = serve_cnt;
    grst_base  = grst_cnt;
    player1_score = 4'd0;
    exp_step("decrease", ev(2, 0, 0, 1, 0, 0));
    start_btn = 1'b1;
    exp_step("start_in_play", ev(2, 0, 0, 1, 0, 0));
    start_btn = 1'b0;
    step();
    exp_step("play_stable", ev(2, 0, 0, 1, 0, 0));
    check("no_pulse_serve", 16'(serve_cnt - serve_base), 16'(0));
    check("no_pulse_grst", 16'(grst_cnt - grst_base), 16'(0));

    // Win for player 2
    player2_score = 4'd9;
    exp_step("p2_point", ev(3, 1, 0, 0, 0, 0));
    run_ticks(89);
    tick_expect("win_p2", ev(4, 1, 0, 0, 0, 2));
    exp_step("over_hold", ev(4, 1, 0, 0, 0, 2));
    start_btn = 1'b1;
    exp_step("over_to_idle", ev(0, 1, 0, 0, 0, 0));
    exp_step("idle_btn_held", ev(0, 1, 0, 0, 0, 0));

    // Mid-serve reset
    player1_score = 4'd0;
    player2_score = 4'd0;
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    exp_step("restart", ev(1, 1, 0, 0, 1, 0));
    run_ticks(30);
    exp_now("serve_mid", ev(1, 1, 0, 0, 0, 0));
    grst_base = grst_cnt;
    rst = 1'b1;
    #1;
    exp_now("rst_async", ev(0, 1, 0, 0, 0, 0));
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
    exp_now("rst_btn_held", ev(0, 1, 0, 0, 0, 0));
    check("rst_no_grst", 16'(grst_cnt - grst_base), 16'(0));
    start_btn = 1'b0;
    exp_step("btn_fall", ev(0, 1, 0, 0, 0, 0));
    start_btn = 1'b1;
    exp_step("rerise", ev(1, 1, 0, 0, 1, 0));
    step();

    check("serve_total", 16'(serve_cnt), 16'(3));
    check("grst_total", 16'(grst_cnt), 16'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
